// File: rtl/passcode_frame_encoder_if.sv
// Digit-entry / frame handshake bundle for passcode_frame_encoder.
//   slave  : encoder side (takes digits and control, drives frame/status)
//   master : upstream keypad logic and downstream compare stage
// Signals: clear, backspace, digit_valid, digit_in[3:0], digit_ready,
//          frame_valid, frame_ready, frame_out[DIGITS*CODE_W-1:0],
//          count[CNT_W-1:0], err
interface passcode_frame_encoder_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned FRAME_W = DIGITS * CODE_W;
  localparam int unsigned CNT_W   = $clog2(DIGITS + 1);

  logic               clear;
  logic               backspace;
  logic               digit_valid;
  logic [3:0]         digit_in;
  logic               digit_ready;
  logic               frame_valid;
  logic               frame_ready;
  logic [FRAME_W-1:0] frame_out;
  logic [CNT_W-1:0]   count;
  logic               err;

  modport slave (
    input  clear, backspace, digit_valid, digit_in, frame_ready,
    output digit_ready, frame_valid, frame_out, count, err
  );

  modport master (
    output clear, backspace, digit_valid, digit_in, frame_ready,
    input  digit_ready, frame_valid, frame_out, count, err
  );
endinterface

// File: rtl/passcode_frame_encoder.sv
// Collects BCD digits over a valid/ready handshake, maps each to its 5-bit
// code and packs DIGITS codes (first digit in the MS slot) into one frame
// held under frame_valid/frame_ready backpressure. Supports backspace/clear.
// Ports: clk, rst_n (async, active low), bus (passcode_frame_encoder_if.slave).
// Optional build macro INVALID_DIGIT_ERR_EN: rejects digits > 9 and pulses
// err for one cycle; without it such digits encode as 00000 and err is 0.
module passcode_frame_encoder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  passcode_frame_encoder_if.slave bus
);
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned FRAME_W = DIGITS * CODE_W;
  localparam int unsigned CNT_W   = $clog2(DIGITS + 1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CODE_W-1:0]  code_c;
  logic               accept_c;
  logic               bad_digit_c;

  // Digit-to-code table; non-BCD inputs map to 00000
  function automatic logic [CODE_W-1:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 5'b00000;
      4'd1:    encode = 5'b00001;
      4'd2:    encode = 5'b10001;
      4'd3:    encode = 5'b10010;
      4'd4:    encode = 5'b01010;
      4'd5:    encode = 5'b01011;
      4'd6:    encode = 5'b11011;
      4'd7:    encode = 5'b11111;
      4'd8:    encode = 5'b01111;
      4'd9:    encode = 5'b01110;
      default: encode = 5'b00000;
    endcase
  endfunction

  assign code_c   = encode(bus.digit_in);
  assign accept_c = bus.digit_valid && (state_q == ST_COLLECT) &&
                    !bus.clear && !bus.backspace;

`ifdef INVALID_DIGIT_ERR_EN
  assign bad_digit_c = (bus.digit_in > 4'd9);
`else
  assign bad_digit_c = 1'b0;
`endif

  // Next-state and datapath; priority clear > backspace > accept > handoff
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    frame_d = frame_q;
    if (bus.clear) begin
      state_d = ST_COLLECT;
      count_d = '0;
      frame_d = '0;
    end else if (bus.backspace) begin
      if (state_q == ST_COLLECT && count_q != '0) begin
        count_d = count_q - CNT_W'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (CNT_W'(i) == count_q - CNT_W'(1))
            frame_d[(DIGITS-1-i)*CODE_W +: CODE_W] = '0;
        end
      end
    end else if (accept_c) begin
      if (!bad_digit_c) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (CNT_W'(i) == count_q)
            frame_d[(DIGITS-1-i)*CODE_W +: CODE_W] = code_c;
        end
        count_d = count_q + CNT_W'(1);
        if (count_q + CNT_W'(1) == CNT_W'(DIGITS))
          state_d = ST_FULL;
      end
    end else if (state_q == ST_FULL && bus.frame_ready) begin
      state_d = ST_COLLECT;
      count_d = '0;
      frame_d = '0;
    end
  end

  // State and frame registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      count_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      frame_q <= frame_d;
    end
  end

`ifdef INVALID_DIGIT_ERR_EN
  logic err_q;

  // One-cycle pulse after a rejected non-BCD digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept_c && bad_digit_c;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Handshake flags are direct decodes of the state flop
  assign bus.digit_ready = (state_q == ST_COLLECT);
  assign bus.frame_valid = (state_q == ST_FULL);
  assign bus.frame_out   = frame_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_passcode_frame_encoder.sv
module tb_passcode_frame_encoder;
  localparam int unsigned DIGITS = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  passcode_frame_encoder_if #(.DIGITS(DIGITS)) bus ();

  passcode_frame_encoder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one digit for exactly one edge; returns at posedge+1
  task automatic send_digit(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit_in    = d;
    @(posedge clk); #1;
    bus.digit_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.count !== 3'd0 || bus.frame_out !== 20'h0 || bus.frame_valid !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs count=%0d frame=%h fv=%b err=%b want 0/0/0/0",
               bus.count, bus.frame_out, bus.frame_valid, bus.err);
    end
    #10 rst_n = 1'b1;
    tick();
    checks++;
    if (bus.digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", bus.digit_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ds [4];
    ds = '{4'd1, 4'd2, 4'd3, 4'd4};
    bus.frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_digit(ds[i]);
      checks++;
      if (bus.count !== 3'(i + 1)) begin
        errors++;
        $display("FAIL b2b_count digit%0d got %0d want %0d", i, bus.count, i + 1);
      end
    end
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_out !== 20'h0C64A || bus.digit_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_frame fv=%b frame=%h rdy=%b want 1/0c64a/0",
               bus.frame_valid, bus.frame_out, bus.digit_ready);
    end
    tick();
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.count !== 3'd0 || bus.frame_out !== 20'h0) begin
      errors++;
      $display("FAIL b2b_handoff fv=%b count=%0d frame=%h want 0/0/0",
               bus.frame_valid, bus.count, bus.frame_out);
    end
  endtask

  task automatic test_backspace_edit();
    logic [3:0] ds [5];
    logic [2:0] exp_cnt [5];
    ds      = '{4'd7, 4'd8, 4'd9, 4'd0, 4'd5};
    exp_cnt = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
    bus.frame_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_digit(ds[i]);
      checks++;
      if (bus.count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL edit_count step%0d got %0d want %0d", i, bus.count, exp_cnt[i]);
      end
      if (i == 1) begin
        bus.backspace = 1'b1;
        tick();
        bus.backspace = 1'b0;
        checks++;
        if (bus.count !== 3'd1 || bus.frame_out !== 20'hF8000) begin
          errors++;
          $display("FAIL edit_bksp count=%0d frame=%h want 1/f8000", bus.count, bus.frame_out);
        end
      end
    end
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_out !== 20'hFB80B) begin
      errors++;
      $display("FAIL edit_frame fv=%b frame=%h want 1/fb80b", bus.frame_valid, bus.frame_out);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.frame_ready = 1'b0;
    send_digit(4'd5);
    send_digit(4'd6);
    send_digit(4'd7);
    send_digit(4'd8);
    bus.digit_valid = 1'b1;
    bus.digit_in    = 4'd3;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_out !== 20'h5EFEF ||
          bus.digit_ready !== 1'b0 || bus.count !== 3'd4) begin
        errors++;
        $display("FAIL hold_cycle%0d fv=%b frame=%h rdy=%b count=%0d want 1/5efef/0/4",
                 c, bus.frame_valid, bus.frame_out, bus.digit_ready, bus.count);
      end
      tick();
    end
    bus.digit_valid = 1'b0;
    bus.frame_ready = 1'b1;
    tick();
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.digit_ready !== 1'b1 || bus.count !== 3'd0 || bus.frame_out !== 20'h0) begin
      errors++;
      $display("FAIL hold_release fv=%b rdy=%b count=%0d frame=%h want 0/1/0/0",
               bus.frame_valid, bus.digit_ready, bus.count, bus.frame_out);
    end
  endtask

  task automatic test_priority();
    send_digit(4'd1);
    send_digit(4'd2);
    send_digit(4'd3);
    bus.digit_valid = 1'b1;
    bus.digit_in    = 4'd6;
    bus.backspace   = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
    checks++;
    if (bus.count !== 3'd2 || bus.frame_out !== 20'h0C400) begin
      errors++;
      $display("FAIL prio_bksp count=%0d frame=%h want 2/0c400", bus.count, bus.frame_out);
    end
    bus.clear = 1'b1;
    tick();
    bus.clear     = 1'b0;
    bus.backspace = 1'b0;
    checks++;
    if (bus.count !== 3'd0 || bus.frame_out !== 20'h0) begin
      errors++;
      $display("FAIL prio_clear count=%0d frame=%h want 0/0", bus.count, bus.frame_out);
    end
    // Clear beats frame_ready while FULL
    send_digit(4'd9);
    send_digit(4'd9);
    send_digit(4'd9);
    send_digit(4'd9);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.count !== 3'd0 || bus.frame_out !== 20'h0) begin
      errors++;
      $display("FAIL prio_clear_full fv=%b count=%0d frame=%h want 0/0/0",
               bus.frame_valid, bus.count, bus.frame_out);
    end
  endtask

  task automatic test_invalid_digit();
    send_digit(4'd1);
    send_digit(4'hA);
`ifdef INVALID_DIGIT_ERR_EN
    checks++;
    if (bus.err !== 1'b1 || bus.count !== 3'd1 || bus.frame_out !== 20'h08000) begin
      errors++;
      $display("FAIL inv_reject err=%b count=%0d frame=%h want 1/1/08000",
               bus.err, bus.count, bus.frame_out);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL inv_pulse_width err=%b want 0", bus.err);
    end
`else
    checks++;
    if (bus.err !== 1'b0 || bus.count !== 3'd2 || bus.frame_out !== 20'h08000) begin
      errors++;
      $display("FAIL inv_accept err=%b count=%0d frame=%h want 0/2/08000",
               bus.err, bus.count, bus.frame_out);
    end
`endif
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic test_async_reset();
    send_digit(4'd4);
    send_digit(4'd4);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.frame_out !== 20'h0 || bus.frame_valid !== 1'b0 ||
        bus.err !== 1'b0 || bus.digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset count=%0d frame=%h fv=%b err=%b rdy=%b want 0/0/0/0/1",
               bus.count, bus.frame_out, bus.frame_valid, bus.err, bus.digit_ready);
    end
    #3 rst_n = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_digit(4'd2);
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_out !== 20'h8C631) begin
      errors++;
      $display("FAIL post_reset_frame fv=%b frame=%h want 1/8c631", bus.frame_valid, bus.frame_out);
    end
    bus.frame_ready = 1'b1;
    tick();
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.clear       = 1'b0;
    bus.backspace   = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.frame_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_backspace_edit();
    test_backpressure();
    test_priority();
    test_invalid_digit();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
